// File: rtl/arm_lsu_pkg.sv
// Shared types and helpers for the ARM load/store unit.
package arm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } lsu_state_t;

  localparam int LANE_BITS = 8;

  function automatic int size_bytes(input lsu_size_t size);
    case (size)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/arm_lsu_if.sv
// Core-side request/response and memory-side command/read-data bundle of the LSU.
interface arm_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_fault;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_valid, mem_write, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_valid, mem_write, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arm_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store replication and load
// extract/extend, all purely combinational.
module arm_lsu_align
  import arm_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  lsu_size_t         size,
  input  logic [OFF_W-1:0]  off,
  input  logic              load_signed,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  int                nbytes;
  int                keep;
  logic [DATA_W-1:0] shifted;
  logic              msb;
  logic              sign;

  always_comb begin
    nbytes = size_bytes(size);
    if (nbytes > NB) nbytes = NB;
    keep = nbytes * LANE_BITS;

    be = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(off) && i < int'(off) + nbytes) be[i] = 1'b1;
    end

    case (size)
      SZ_B:    wdata_rep = {NB{wdata[7:0]}};
      SZ_H:    wdata_rep = {(NB/2){wdata[15:0]}};
      SZ_W:    wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    shifted = rdata >> (int'(off) * LANE_BITS);
    case (size)
      SZ_B:    msb = shifted[7];
      SZ_H:    msb = shifted[15];
      SZ_W:    msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    // Full-width loads have nothing to extend, so req_signed is moot there.
    sign = load_signed && (keep < DATA_W) && msb;
    for (int j = 0; j < DATA_W; j++) begin
      rdata_ext[j] = (j < keep) ? shifted[j] : sign;
    end
  end

endmodule

// File: rtl/arm_lsu.sv
// Load/store unit FSM: accepts one core request at a time, drives a valid/ready
// memory command, waits for read data and returns a one-cycle response.
module arm_lsu
  import arm_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      reset,
  arm_lsu_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state, state_n;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_t         size_q;
  logic              signed_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              fault_q, fault_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              stale_q, stale_n;
  logic              capture;

  lsu_size_t         req_size;
  logic              misaligned;
  logic              illegal;
  logic              expired;

  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;
  logic              in_issue;
  logic              in_resp;

  assign req_size = lsu_size_t'(bus.req_size);
  assign illegal  = (req_size == SZ_D) && (DATA_W == 32);
  assign expired  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    case (req_size)
      SZ_H:    misaligned = bus.req_addr[0];
      SZ_W:    misaligned = |bus.req_addr[1:0];
      SZ_D:    misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  arm_lsu_align #(.DATA_W(DATA_W)) u_align (
    .size        (size_q),
    .off         (addr_q[OFF_W-1:0]),
    .load_signed (signed_q),
    .wdata       (wdata_q),
    .rdata       (bus.mem_rdata),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt_q    <= '0;
      stale_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state   <= state_n;
      cnt_q   <= cnt_n;
      stale_q <= stale_n;
      fault_q <= fault_n;
      rdata_q <= rdata_n;
      if (capture) begin
        addr_q   <= bus.req_addr;
        size_q   <= req_size;
        signed_q <= bus.req_signed;
        write_q  <= bus.req_write;
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  // A read that timed out in WAIT_R still owes one mem_rvalid; stale swallows
  // it whenever it shows up, including inside a later read's WAIT_R.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    stale_n = stale_q;
    fault_n = fault_q;
    rdata_n = rdata_q;
    capture = 1'b0;

    if (stale_q && bus.mem_rvalid) stale_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          cnt_n   = '0;
          rdata_n = '0;
          if (misaligned || illegal) begin
            fault_n = 1'b1;
            state_n = RESP;
          end else begin
            fault_n = 1'b0;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          cnt_n   = '0;
          state_n = write_q ? RESP : WAIT_R;
        end else if (expired) begin
          fault_n = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid && !stale_q) begin
          rdata_n = rdata_ext;
          state_n = RESP;
        end else if (expired) begin
          fault_n = 1'b1;
          stale_n = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Command fields are gated to ISSUE so they read as zero whenever mem_valid is low.
  assign in_issue       = (state == ISSUE);
  assign in_resp        = (state == RESP);
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_valid  = in_issue;
  assign bus.mem_write  = in_issue & write_q;
  assign bus.mem_be     = in_issue ? be : '0;
  assign bus.mem_addr   = in_issue ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.mem_wdata  = in_issue ? wdata_rep : '0;
  assign bus.resp_valid = in_resp;
  assign bus.resp_fault = in_resp & fault_q;
  assign bus.resp_rdata = in_resp ? rdata_q : '0;

endmodule

// File: doc/arm_lsu.md
Name: arm_lsu

Overview:
- Parametrised load/store unit between the ARM core's memory-stage outputs and a wait-stated data memory.
- Successor to the fixed single-cycle word/byte-enable data path: generalised to DATA_W of 32 or 64, adds halfword/doubleword sizes, signed loads, a valid/ready memory handshake, misalignment faults and a timeout watchdog.
- The core stalls on req_ready low and consumes a one-cycle resp_valid pulse.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, maximum cycles waiting on memory before a fault; must be ≥ 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load result after extension; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid: misaligned, illegal size, or timeout.
- mem_valid  out  1  memory command valid.
- mem_ready  in  1  memory accepts the command.
- mem_write  out  1  command is a write.
- mem_be  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address with the low log2(DATA_W/8) bits forced to 0.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0 except req_ready = 1; state = IDLE; timeout counter = 0; stale = 0. Reset mid-transaction drops mem_valid immediately and returns to IDLE.
- States:
  - IDLE: accept a request on req_valid && req_ready; register addr, size, signed, write and wdata.
    - Misaligned (addr mod 2^size ≠ 0) or size 11 with DATA_W = 32 → RESP with fault. No memory command is issued.
    - Otherwise → ISSUE.
  - ISSUE: mem_valid = 1 with all mem_* outputs held stable.
    - mem_ready = 1 and write → RESP.
    - mem_ready = 1 and read → WAIT_R.
  - WAIT_R: wait for mem_rvalid, then register the extracted data → RESP. A mem_rvalid in the same cycle as ISSUE acceptance is ignored; the memory returns data ≥ 1 cycle after acceptance.
  - RESP: resp_valid = 1 for exactly one cycle → IDLE.
- Latency, with the request accepted at cycle 0:
  - mem_valid first high at cycle 1.
  - Zero-wait write: resp_valid at cycle 2.
  - Zero-wait read with mem_rvalid at cycle 2: resp_valid at cycle 3.
  - Fault: resp_valid at cycle 1.
- Byte enables: off = addr[log2(DATA_W/8)-1:0]; mem_be = ((1 << 2^size) − 1) << off.
- Store data: mem_wdata replicates the low 2^size bytes of wdata across every lane.
- Load data: rdata shifted right by off×8, masked to 2^size bytes, then sign-extended if req_signed else zero-extended to DATA_W. Full-width loads ignore req_signed.
- Timeout:
  - The counter clears on entering ISSUE and on ISSUE→WAIT_R, and increments each cycle spent in ISSUE or WAIT_R.
  - Reaching TIMEOUT → RESP with fault; mem_valid drops.
  - Timeout from WAIT_R sets stale = 1.
- Stale:
  - While stale = 1, the next mem_rvalid is discarded and clears stale, in any state.
  - If that discard coincides with WAIT_R of a new read, the pulse is consumed as stale and is not used as data.
- resp_valid and mem_valid are never high in the same cycle.
- req_ready is low in ISSUE, WAIT_R and RESP.

Decomposition:
- arm_lsu_pkg holds:
  - typedef lsu_size_t: SZ_B, SZ_H, SZ_W, SZ_D.
  - typedef lsu_state_t: IDLE, ISSUE, WAIT_R, RESP.
  - function size_bytes.
  - constant LANE_BITS.
- One sub-module, arm_lsu_align: combinational be, store replication, and load extract/extend, parametrised by DATA_W. Instantiated once; the FSM lives in arm_lsu.

Test Plan:
1. DATA_W=32, LDRSB addr 0x103, mem_rdata 0x80FFFFFF, zero wait → mem_be 0b1000, mem_addr 0x100, resp_rdata 0xFFFFFF80 at cycle 3, fault 0.
2. STRH addr 0x202, wdata 0x1234ABCD, mem_ready delayed 3 cycles → mem_wdata 0xABCDABCD, mem_be 0b1100 held stable throughout, resp_valid exactly once.
3. LDR word at 0x101 → resp_valid at cycle 1 with fault 1; mem_valid never asserts.
4. DATA_W=64, dword load at 0x8 with rdata 0x0123456789ABCDEF → mem_be 0xFF, resp_rdata unchanged; then size 11 on DATA_W=32 → fault.
5. TIMEOUT=4, read with mem_rvalid withheld → fault 4 cycles after acceptance. Then a late mem_rvalid (0xDEAD) during the next read's WAIT_R is discarded; the following mem_rvalid 0x55 → resp_rdata 0x55.
6. Reset asserted during WAIT_R → mem_valid/resp_valid 0 immediately, req_ready 1, stale 0; a post-reset LDRB at 0x0 completes normally.
